ncl_add_initiator: RTL

NCL_ADD_INITIATOR -- requirements
Module: ncl_add_initiator

---
 rtl/ncl_add_initiator.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ncl_add_initiator.sv
// rtl/ncl_add_initiator.sv - binary request/response front end driving an NCL dual-rail adder
//
// Purpose:
//   Accepts a binary add request (op_a, op_b, op_cin), presents it to an NCL
//   adder as a dual-rail DATA wavefront, and collects the dual-rail result.
//   It then runs the NULL return-to-zero phase and hands the decoded binary
//   result back on a valid/ready response port. Each handshake phase is
//   watched by a cycle counter. The result is flagged with rsp_err if the
//   adder stalls or returns an illegal rail pair.
//
// Ports:
//   clk          single clock, all state changes on its rising edge
//   init         asynchronous active-high reset
//   req_valid    host request strobe          req_ready   initiator idle and accepting
//   op_a, op_b   binary operands              op_cin      binary carry-in
//   rsp_valid    result available             rsp_ready   host takes the result
//   rsp_sum      binary sum                   rsp_cout    binary carry-out
//   rsp_err      timeout or illegal rail code seen during this operation
//   A, B         dual-rail operands, bit i on [2i] false rail / [2i+1] true rail
//   carryin      dual-rail carry-in ([0] false, [1] true)
//   ABCOMP       per-bit completion from the adder for A/B
//   carryinCOMP  completion from the adder for carryin
//   sum          dual-rail sum from the adder
//   carryout     dual-rail carry-out from the adder
//   sumCOMP      per-bit acknowledge back to the adder for sum
//   carryCOMP    acknowledge back to the adder for carryout

module ncl_add_initiator #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 init,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic                 op_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_err,
    output logic [2*WIDTH-1:0]   A,
    output logic [2*WIDTH-1:0]   B,
    output logic [1:0]           carryin,
    input  logic [WIDTH-1:0]     ABCOMP,
    input  logic                 carryinCOMP,
    input  logic [2*WIDTH-1:0]   sum,
    input  logic [1:0]           carryout,
    output logic [WIDTH-1:0]     sumCOMP,
    output logic                 carryCOMP
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TX_DATA = 3'd1;
    localparam logic [2:0] S_TX_NULL = 3'd2;
    localparam logic [2:0] S_ACK_REL = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    // The counter value seen at the last permitted edge of a phase; the phase
    // has then lasted TIMEOUT cycles.
    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizers for everything arriving from the async adder
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   r_abcomp_s1, r_abcomp_s2;
    logic               r_cicomp_s1, r_cicomp_s2;
    logic [2*WIDTH-1:0] r_sum_s1,    r_sum_s2;
    logic [1:0]         r_cout_s1,   r_cout_s2;

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_abcomp_s1 <= '0;
            r_abcomp_s2 <= '0;
            r_cicomp_s1 <= 1'b0;
            r_cicomp_s2 <= 1'b0;
            r_sum_s1    <= '0;
            r_sum_s2    <= '0;
            r_cout_s1   <= 2'b00;
            r_cout_s2   <= 2'b00;
        end else begin
            r_abcomp_s1 <= ABCOMP;
            r_abcomp_s2 <= r_abcomp_s1;
            r_cicomp_s1 <= carryinCOMP;
            r_cicomp_s2 <= r_cicomp_s1;
            r_sum_s1    <= sum;
            r_sum_s2    <= r_sum_s1;
            r_cout_s1   <= carryout;
            r_cout_s2   <= r_cout_s1;
        end
    end

    // ------------------------------------------------------------------
    // Inbound wavefront classification (synchronized values only)
    // ------------------------------------------------------------------
    logic             w_complete;
    logic             w_null;
    logic             w_illegal;
    logic [WIDTH-1:0] w_dec_sum;
    logic             w_dec_cout;
    logic             w_comp_all1;
    logic             w_comp_all0;

    always_comb begin
        w_complete = 1'b1;
        w_null     = 1'b1;
        w_illegal  = 1'b0;
        w_dec_sum  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            // Equal rails are either 00 (still null) or 11 (illegal): not complete.
            if (r_sum_s2[2*i] == r_sum_s2[2*i+1]) begin
                w_complete = 1'b0;
            end
            if (r_sum_s2[2*i] | r_sum_s2[2*i+1]) begin
                w_null = 1'b0;
            end
            if (r_sum_s2[2*i] & r_sum_s2[2*i+1]) begin
                w_illegal = 1'b1;
            end
            w_dec_sum[i] = r_sum_s2[2*i+1];
        end
        if (r_cout_s2[0] == r_cout_s2[1]) begin
            w_complete = 1'b0;
        end
        if (r_cout_s2[0] | r_cout_s2[1]) begin
            w_null = 1'b0;
        end
        if (r_cout_s2[0] & r_cout_s2[1]) begin
            w_illegal = 1'b1;
        end
    end

    assign w_dec_cout  = r_cout_s2[1];
    assign w_comp_all1 = (&r_abcomp_s2) & r_cicomp_s2;
    assign w_comp_all0 = ~(|r_abcomp_s2) & ~r_cicomp_s2;

    // Binary to dual-rail: a 1 raises the true rail, a 0 raises the false rail.
    function automatic logic [2*WIDTH-1:0] f_enc(input logic [WIDTH-1:0] v);
        logic [2*WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[2*i+:2] = v[i] ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Control FSM. Every outbound rail, acknowledge and response signal is a
    // flop, so the adder never sees a combinational glitch.
    // ------------------------------------------------------------------
    logic [2:0]         r_state;
    logic [15:0]        r_cnt;
    logic               r_req_ready;
    logic [2*WIDTH-1:0] r_a_rail;
    logic [2*WIDTH-1:0] r_b_rail;
    logic [1:0]         r_ci_rail;
    logic [WIDTH-1:0]   r_sum_ack;
    logic               r_cout_ack;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_sum;
    logic               r_rsp_cout;
    logic               r_rsp_err;

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b0;
            r_a_rail    <= '0;
            r_b_rail    <= '0;
            r_ci_rail   <= 2'b00;
            r_sum_ack   <= '0;
            r_cout_ack  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_cout  <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    // Only accept once req_ready is visible to the host. IDLE
                    // is the sole entry to TX_DATA, so the DATA wavefront
                    // never overlaps an outstanding completion.
                    if (req_valid && r_req_ready) begin
                        r_a_rail    <= f_enc(op_a);
                        r_b_rail    <= f_enc(op_b);
                        r_ci_rail   <= op_cin ? 2'b10 : 2'b01;
                        r_rsp_sum   <= '0;
                        r_rsp_cout  <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_cnt       <= '0;
                        r_req_ready <= 1'b0;
                        r_state     <= S_TX_DATA;
                    end
                end

                S_TX_DATA: begin
                    if (w_illegal) begin
                        // A corrupt result is discarded but the NULL phase still
                        // runs so the adder returns to a clean state.
                        r_rsp_err  <= 1'b1;
                        r_rsp_sum  <= '0;
                        r_rsp_cout <= 1'b0;
                        r_a_rail   <= '0;
                        r_b_rail   <= '0;
                        r_ci_rail  <= 2'b00;
                        r_sum_ack  <= '1;
                        r_cout_ack <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_TX_NULL;
                    end else if (w_comp_all1 && w_complete) begin
                        r_rsp_sum  <= w_dec_sum;
                        r_rsp_cout <= w_dec_cout;
                        r_a_rail   <= '0;
                        r_b_rail   <= '0;
                        r_ci_rail  <= 2'b00;
                        r_sum_ack  <= '1;
                        r_cout_ack <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_TX_NULL;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_sum   <= '0;
                        r_rsp_cout  <= 1'b0;
                        r_a_rail    <= '0;
                        r_b_rail    <= '0;
                        r_ci_rail   <= 2'b00;
                        r_sum_ack   <= '0;
                        r_cout_ack  <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_TX_NULL: begin
                    if (w_comp_all0 && w_null) begin
                        r_sum_ack  <= '0;
                        r_cout_ack <= 1'b0;
                        r_state    <= S_ACK_REL;
                    end else if (r_cnt == LP_CNT_LAST) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_sum   <= '0;
                        r_rsp_cout  <= 1'b0;
                        r_sum_ack   <= '0;
                        r_cout_ack  <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end

                S_ACK_REL: begin
                    // Acknowledges were dropped on entry; hold them low one
                    // cycle so the adder sees the release before the response.
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_a_rail    <= '0;
                    r_b_rail    <= '0;
                    r_ci_rail   <= 2'b00;
                    r_sum_ack   <= '0;
                    r_cout_ack  <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_err   = r_rsp_err;
    assign A         = r_a_rail;
    assign B         = r_b_rail;
    assign carryin   = r_ci_rail;
    assign sumCOMP   = r_sum_ack;
    assign carryCOMP = r_cout_ack;

endmodule
